// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl
//  Purpose  : Data-memory access controller between the MEM stage and a
//             word-wide SRAM. Handles byte/half/word loads with sign or zero
//             extension, sub-word stores by read-modify-write, and stalls the
//             pipeline while an access is in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WS   = 3'd2,
    S_WP   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [15:0] C_RD_LAST = 16'(RD_WAIT - 1);
  localparam logic [15:0] C_WR_LAST = 16'(WR_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic        r_err;

  logic        w_misalign;
  logic        w_rd_last;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign w_rd_last  = (r_state == S_RD) && (r_cnt == C_RD_LAST);

  // Byte lane extraction and read-modify-write merge (big-endian lanes)
  always_comb begin
    w_byte  = 8'h00;
    w_merge = mem_dout;
    case (r_off)
      2'd0:    w_byte = mem_dout[31:24];
      2'd1:    w_byte = mem_dout[23:16];
      2'd2:    w_byte = mem_dout[15:8];
      default: w_byte = mem_dout[7:0];
    endcase
    w_half = r_off[1] ? mem_dout[15:0] : mem_dout[31:16];
    case (r_size)
      2'b00:   w_load = r_sign ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      2'b01:   w_load = r_sign ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: w_load = mem_dout;
    endcase
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0:    w_merge[31:24] = r_wdata[7:0];
        2'd1:    w_merge[23:16] = r_wdata[7:0];
        2'd2:    w_merge[15:8]  = r_wdata[7:0];
        default: w_merge[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_off[1]) begin
      w_merge[15:0] = r_wdata;
    end else begin
      w_merge[31:16] = r_wdata;
    end
  end

  // Next-state decode and SRAM control outputs
  always_comb begin
    w_next = r_state;
    mem_cs = 1'b0;
    mem_oe = 1'b0;
    mem_we = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = req & ~rst;
        if (req) begin
          if (w_misalign)            w_next = S_DONE;
          else if (!wr || !size[1])  w_next = S_RD;
          else                       w_next = S_WS;
        end
      end
      S_RD: begin
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        busy   = 1'b1;
        if (w_rd_last) w_next = r_wr ? S_WS : S_DONE;
      end
      S_WS: begin
        mem_cs = 1'b1;
        busy   = 1'b1;
        w_next = S_WP;
      end
      S_WP: begin
        mem_cs = 1'b1;
        mem_we = 1'b1;
        busy   = 1'b1;
        if (r_cnt == C_WR_LAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register with a per-state cycle counter cleared on every transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'h0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 16'h0 : r_cnt + 16'd1;
    end
  end

  // Request latch, SRAM address/data registers and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_size   <= 2'b00;
      r_sign   <= 1'b0;
      r_off    <= 2'b00;
      r_wdata  <= 16'h0;
      r_err    <= 1'b0;
      rdata    <= 32'h0;
      mem_addr <= 32'h0;
      mem_din  <= 32'h0;
    end else begin
      if (r_state == S_IDLE && req) begin
        r_wr    <= wr;
        r_size  <= size;
        r_sign  <= sign_ext;
        r_off   <= addr[1:0];
        r_wdata <= wdata[15:0];
        r_err   <= w_misalign;
        // Misaligned requests leave the SRAM pins untouched
        if (!w_misalign) begin
          mem_addr <= {addr[31:2], 2'b00};
          if (wr && size[1]) mem_din <= wdata;
        end
      end
      if (w_rd_last) begin
        if (r_wr) mem_din <= w_merge;
        else      rdata   <= w_load;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_ctrl
//  Purpose  : Scoreboard bench for dmem_ctrl with an SRAM model and a
//             behavioural reference of load/store semantics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic        mem_cs, mem_oe, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  dmem_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: 16 words, written while selected with write enable high
  logic [31:0] sram [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_val = 32'h0;
  always @(posedge clk) begin
    if (mem_cs && mem_we)  sram[mem_addr[5:2]] <= mem_din;
    else if (pre_we)       sram[pre_idx] <= pre_val;
  end
  assign mem_dout = (mem_cs && mem_oe) ? sram[mem_addr[5:2]] : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    logic        cs;
    logic        we;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] ref_mem [0:15];
  logic [31:0] ref_rdata = 32'h0;
  int          issue_id = 0;

  // Monitor: bus invariants every cycle, scoreboard pop on each done pulse
  int          seen_id = 0;
  logic        cs_seen = 1'b0, we_seen = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_din = 32'h0;
  always @(negedge clk) begin
    if (issue_id != seen_id) begin
      seen_id = issue_id;
      cs_seen = 1'b0;
      we_seen = 1'b0;
    end
    cs_seen = cs_seen | mem_cs;
    we_seen = we_seen | mem_we;
    if (!rst) begin
      if (mem_cs) check("oe_we_exclusive", {31'h0, mem_oe & mem_we}, 32'h0);
      if (mem_we) begin
        check("we_addr_stable", mem_addr, prev_addr);
        check("we_din_stable", mem_din, prev_din);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("err", {31'h0, err}, {31'h0, e.err});
          check("rdata", rdata, e.rdata);
          check("busy_at_done", {31'h0, busy}, 32'h0);
          check("cs_activity", {31'h0, cs_seen}, {31'h0, e.cs});
          check("we_activity", {31'h0, we_seen}, {31'h0, e.we});
        end
      end
    end
    prev_we   = mem_we;
    prev_addr = mem_addr;
    prev_din  = mem_din;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    pre_idx = 4'(idx); pre_val = val; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference semantics: alignment, big-endian lanes, extension, merge, latency
  function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd, input int c0);
    exp_t        e;
    int          idx = int'(a[5:2]);
    int          o   = int'(a[1:0]);
    logic [31:0] word = ref_mem[idx];
    logic [31:0] v;
    int          sh;
    bit          mis = (sz == 2'b01 && o % 2 == 1) || (sz >= 2'b10 && o != 0);
    e.err = 1'b0; e.cs = 1'b1; e.we = w;
    if (mis) begin
      e.err = 1'b1; e.cs = 1'b0; e.we = 1'b0;
      e.cyc = c0 + 1;
    end else if (!w) begin
      if (sz == 2'b00) begin
        v = (word >> (8 * (3 - o))) & 32'hFF;
        if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (word >> (16 * (1 - o / 2))) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      ref_rdata = v;
      e.cyc = c0 + RD_WAIT + 1;
    end else if (sz >= 2'b10) begin
      ref_mem[idx] = wd;
      e.cyc = c0 + WR_WAIT + 2;
    end else begin
      if (sz == 2'b00) begin
        sh = 8 * (3 - o);
        v  = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        sh = 16 * (1 - o / 2);
        v  = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      ref_mem[idx] = v;
      e.cyc = c0 + RD_WAIT + WR_WAIT + 2;
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(posedge clk); #1;
    wr = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    sb_q.push_back(model(w, sz, sx, a, wd, cyc));
    issue_id++;
    @(posedge clk); #1;
    req = 1'b0;
    wr = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'h0, 32'h1);
      sb_q.delete();
    end
    check("sram_word", sram[a[5:2]], ref_mem[a[5:2]]);
  endtask

  task automatic check_reset_outputs();
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_ctrl", {26'h0, busy, done, err, mem_cs, mem_oe, mem_we}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] keep;
    for (int i = 0; i < 16; i++) begin
      sram[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    req = 1'b1; wr = 1'b1; addr = 32'h10;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed loads
    preload(4, 32'h1234_5678);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    preload(4, 32'h1234_56F8);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);

    // Directed stores
    preload(4, 32'h1234_5678);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    check("sb_result", sram[4], 32'h12AA_5678);
    preload(4, 32'h1234_5678);
    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
    check("sh_result", sram[4], 32'h1234_BEEF);
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_result", sram[4], 32'hDEAD_BEEF);

    // Misaligned accesses
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    access(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234);
    access(1'b0, 2'b11, 1'b1, 32'h31, 32'h0);

    // Reset during the read phase of a byte store: no write must happen
    preload(4, 32'h1234_5678);
    @(posedge clk); #1;
    wr = 1'b1; size = 2'b00; addr = 32'h11; wdata = 32'hAA; req = 1'b1;
    issue_id++;
    @(posedge clk); #2;
    req = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    check("abort_no_we", {31'h0, we_seen}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    check("abort_sram", sram[4], 32'h1234_5678);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("post_abort_lw", rdata, 32'h1234_5678);

    // Randomized traffic
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int i = 0; i < 250; i++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom), {26'h0, 6'($urandom)}, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // Mid-operation reset on a random access, then one clean load
    @(posedge clk); #1;
    wr = 1'b0; size = 2'b10; addr = 32'h20; req = 1'b1;
    issue_id++;
    @(posedge clk); #3;
    req = 1'b1; wr = 1'($urandom); addr = $urandom;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = 32'h0;
    keep = ref_mem[8];
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("final_lw", rdata, keep);

    for (int i = 0; i < 16; i++) check("final_mem", sram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the pipeline MEM stage and the word-wide `gac_sram` data memory. It accepts one load or store per request and drives the SRAM `cs`/`oe`/`we`/`addr`/`din` lines in a glitch-safe sequence. Sub-word stores are handled by read-modify-write. Loads return byte, halfword or word data with sign or zero extension, and the block stalls the pipeline for the duration of each access.

## Interface
- `RD_WAIT`, default 1: cycles `mem_oe` is held before `mem_dout` is captured (≥1).
- `WR_WAIT`, default 1: cycles `mem_we` is held high (≥1).

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  access request; sampled only in IDLE.
- `wr`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `rdata`  out  32  load result (registered).
- `busy`  out  1  stall to pipeline.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misaligned access; valid only with `done`.
- `mem_cs`, `mem_oe`, `mem_we`  out  1 each  SRAM controls.
- `mem_addr`  out  32  word address: `{addr[31:2],2'b00}`.
- `mem_din`  out  32  SRAM write data.
- `mem_dout`  in  32  SRAM read data.

## Operation
- Byte order is big-endian: byte offset 0 is bits [31:24] and offset 3 is bits [7:0]. Halfword offset 0 is [31:16].
- Misaligned access: half with `addr[0]`=1, or word with `addr[1:0]`≠0. No SRAM activity; the block goes to DONE with `err`=1.
- States:
  - IDLE
  - RD: `cs`=1, `oe`=1, `we`=0.
  - WS, write setup: `cs`=1, `oe`=0, `we`=0, addr and din stable.
  - WP, write pulse: `cs`=1, `we`=1.
  - DONE: `cs`=0, `oe`=0, `we`=0, addr and din held.
- Transitions:
  - IDLE on `req`: to DONE if misaligned; to RD if load or sub-word store; to WS if word store.
  - RD after `RD_WAIT` cycles: to DONE for a load (`rdata` updated with the extracted/extended value); to WS for a store (merged word latched into `mem_din`).
  - WS → WP after 1 cycle. WP → DONE after `WR_WAIT` cycles. DONE → IDLE always.
- Request fields (`wr`, `size`, `sign_ext`, `addr`, `wdata`) are latched at acceptance. Later input changes are ignored until IDLE.
- Merge: the selected byte or halfword of the read word is replaced by `wdata[7:0]` or `wdata[15:0]`; the other bytes are kept.
- `busy` = (state ∉ {IDLE, DONE}) OR (state==IDLE AND `req`). This is combinational so the pipeline stalls in the same cycle as the request.
- `req` seen in DONE is not a new request; the next access is accepted from IDLE.
- `mem_oe` and `mem_we` are never both 1.
- `mem_addr`/`mem_din` change only while `mem_we`=0. `mem_we` never rises in the same cycle as an address change (the SRAM model writes on any input event).
- `rdata` holds its value across stores and errors. It changes only at load completion.

## Timing
- Cycle 0 is the cycle `req` is high in IDLE. Completion (`done`=1) occurs in:
  - misaligned: cycle 1
  - load: cycle `RD_WAIT`+1 (2 at defaults)
  - word store: cycle `WR_WAIT`+2 (3 at defaults)
  - sub-word store: cycle `RD_WAIT`+`WR_WAIT`+2 (4 at defaults)
- `mem_dout` is sampled on the edge ending the last RD cycle. `rdata` is valid from the DONE cycle onward.
- Reset values: all outputs 0 and state IDLE, including `rdata`, `mem_addr` and `mem_din`.
- Reset mid-operation:
  - Controls drop asynchronously and no `done` pulse is produced.
  - Reset during RD of a sub-word store: no write occurs.
  - Reset during WP: the write is not guaranteed either way.
- Back-to-back: minimum 1 IDLE cycle between DONE and the next acceptance.

## Test plan
- Reset: assert `rst` mid-cycle with arbitrary inputs → all outputs 0 immediately; state IDLE after release.
- Word load: SRAM[0x10]=0x12345678, lw 0x10 → `mem_oe` high in cycle 1, `done`+`rdata`=0x12345678 in cycle 2, `mem_we` never high.
- Sub-word loads: SRAM[0x10]=0x123456F8.
  - lb signed 0x13 → 0xFFFFFFF8
  - lbu 0x13 → 0x000000F8
  - lh signed 0x12 → 0x000056F8
  - lhu 0x10 → 0x00001234
- Stores: SRAM[0x10]=0x12345678.
  - sb 0x11, `wdata`=0xAA → SRAM 0x12AA5678, `done` in cycle 4.
  - sh 0x12, 0xBEEF → 0x1234BEEF.
  - sw 0x10, 0xDEADBEEF → `done` in cycle 3, and `we` rises one cycle after `cs`.
- Misaligned: lw 0x12 or sh 0x11 → `done`=`err`=1 in cycle 1, `mem_cs` never asserted, SRAM and `rdata` unchanged.
- Reset during RD of sb 0x11 → no `mem_we` pulse, SRAM unchanged; a following lw 0x10 returns 0x12345678 normally.
